// File: rtl/dma_pkg.sv
// Shared definitions for the DMA priority resolver.
// Contents:
//   - channel count
//   - command register bit positions
//   - resolver FSM state type
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  // Command register bit positions
  localparam int unsigned CMD_DIS     = 0;  // controller disable
  localparam int unsigned CMD_ROT     = 1;  // rotating priority
  localparam int unsigned CMD_DREQ_LO = 2;  // DREQ inputs active-low
  localparam int unsigned CMD_DACK_HI = 3;  // DACK outputs active-high

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    SERVICE
  } state_e;

endpackage

// File: rtl/dma_priority_resolver_if.sv
// Bus bundle between the DMA priority resolver and its environment.
// Signals:
//   dreq, mask_wr/mask_din, cmd_wr/cmd_din  request and register-write inputs
//   hlda, validDACK, eop                    CPU and timing-control handshakes
//   hrq, VALID_DREQ0..3, dack               hold request, one-hot grant, acknowledges
// Modports:
//   master  drives the inputs (CPU / timing control / bench side)
//   slave   the resolver itself
interface dma_priority_resolver_if;

  logic [3:0] dreq;
  logic       mask_wr;
  logic [3:0] mask_din;
  logic       cmd_wr;
  logic [3:0] cmd_din;
  logic       hlda;
  logic       validDACK;
  logic       eop;
  logic       hrq;
  logic       VALID_DREQ0;
  logic       VALID_DREQ1;
  logic       VALID_DREQ2;
  logic       VALID_DREQ3;
  logic [3:0] dack;

  modport master (
    output dreq, mask_wr, mask_din, cmd_wr, cmd_din, hlda, validDACK, eop,
    input  hrq, VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, dack
  );

  modport slave (
    input  dreq, mask_wr, mask_din, cmd_wr, cmd_din, hlda, validDACK, eop,
    output hrq, VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3, dack
  );

endinterface

// File: rtl/dma_prio_encoder.sv
// Combinational circular priority search over the four channels.
// Ports:
//   req_i           effective requests
//   prio_ptr_i      channel with highest priority; the search runs upward from it and wraps
//   grant_onehot_o  one-hot winner (zero if there are no requests)
//   grant_idx_o     index of the winner (zero if there are no requests)
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [1:0]        prio_ptr_i,
  output logic [NUM_CH-1:0] grant_onehot_o,
  output logic [1:0]        grant_idx_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    found          = 1'b0;
    idx            = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      // 2-bit add gives the mod-4 wrap
      idx = prio_ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        found               = 1'b1;
        grant_idx_o         = idx;
        grant_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// Four-channel DMA request arbiter.
// Function:
//   - Conditions the raw DREQ inputs with command polarity, mask and disable.
//   - Raises hrq to the CPU.
//   - On hlda, latches a one-hot grant using fixed or rotating priority.
//   - Drives DACK while timing control reports validDACK.
//   - Releases the bus on eop, or when hlda is withdrawn.
// Ports:
//   CLK    system clock
//   RESET  synchronous active-high reset
//   bus    dma_priority_resolver_if.slave (requests, register writes, handshakes, grant, dack)
module dma_priority_resolver
  import dma_pkg::*;
(
  input logic                     CLK,
  input logic                     RESET,
  dma_priority_resolver_if.slave  bus
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] dreq_q, dreq_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [1:0]        prio_ptr_q, prio_ptr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [1:0]        grant_idx_q, grant_idx_d;
  logic              hrq_q, hrq_d;

  logic [NUM_CH-1:0] req_eff;
  logic [1:0]        search_ptr;
  logic [NUM_CH-1:0] enc_onehot;
  logic [1:0]        enc_idx;
  logic [NUM_CH-1:0] dack_act;

  // Effective requests use the registered dreq and the current register contents,
  // so register writes are seen one cycle after they are made.
  assign req_eff = (dreq_q ^ {NUM_CH{cmd_q[CMD_DREQ_LO]}}) & ~mask_q
                   & {NUM_CH{~cmd_q[CMD_DIS]}};

  // Fixed priority is simply a circular search that starts at channel 0
  assign search_ptr = cmd_q[CMD_ROT] ? prio_ptr_q : 2'd0;

  dma_prio_encoder u_prio_encoder (
    .req_i          (req_eff),
    .prio_ptr_i     (search_ptr),
    .grant_onehot_o (enc_onehot),
    .grant_idx_o    (enc_idx)
  );

  always_comb begin
    state_d     = state_q;
    dreq_d      = bus.dreq;
    mask_d      = bus.mask_wr ? bus.mask_din : mask_q;
    cmd_d       = bus.cmd_wr ? bus.cmd_din : cmd_q;
    prio_ptr_d  = prio_ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;

    unique case (state_q)
      IDLE: begin
        if (|req_eff) state_d = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (!(|req_eff)) begin
          state_d = IDLE;
        end else if (bus.hlda) begin
          state_d     = SERVICE;
          grant_d     = enc_onehot;
          grant_idx_d = enc_idx;
        end
      end
      SERVICE: begin
        // Mask/disable changes never abort a service in progress; eop beats a dropped hlda
        if (bus.eop) begin
          state_d = IDLE;
          grant_d = '0;
          if (cmd_q[CMD_ROT]) prio_ptr_d = grant_idx_q + 2'd1;
        end else if (!bus.hlda) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Switching to fixed priority restarts the rotation from channel 0
    if (bus.cmd_wr && !bus.cmd_din[CMD_ROT]) prio_ptr_d = '0;

    hrq_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      dreq_q      <= '0;
      mask_q      <= 4'hF;
      cmd_q       <= 4'h0;
      prio_ptr_q  <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      hrq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dreq_q      <= dreq_d;
      mask_q      <= mask_d;
      cmd_q       <= cmd_d;
      prio_ptr_q  <= prio_ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      hrq_q       <= hrq_d;
    end
  end

  // dack follows validDACK combinationally; polarity set by the command register
  assign dack_act = (state_q == SERVICE && bus.validDACK) ? grant_q : '0;
  assign bus.dack = cmd_q[CMD_DACK_HI] ? dack_act : ~dack_act;

  assign bus.hrq         = hrq_q;
  assign bus.VALID_DREQ0 = grant_q[0];
  assign bus.VALID_DREQ1 = grant_q[1];
  assign bus.VALID_DREQ2 = grant_q[2];
  assign bus.VALID_DREQ3 = grant_q[3];

endmodule

// File: doc/dma_priority_resolver.md
# dma_priority_resolver

Four-channel DMA request arbiter for the 8237A-style controller. It conditions raw DREQ inputs with command polarity, mask and disable, and raises hrq to the CPU. On hlda it resolves fixed or rotating priority and presents a one-hot grant (VALID_DREQ0..3) to the timing-control block. It drives DACK while timing control reports validDACK, and releases the bus on end-of-process.

## Interface
- Parameters: none (channel count fixed at 4)
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- dreq  in  4  raw channel requests, polarity per cmd[2]
- mask_wr  in  1  load mask register from mask_din
- mask_din  in  4  mask bits, 1 = channel masked
- cmd_wr  in  1  load command register from cmd_din
- cmd_din  in  4  [0] controller disable, [1] rotating priority, [2] DREQ active-low, [3] DACK active-high
- hlda  in  1  hold acknowledge from CPU
- validDACK  in  1  from timing control: transfer cycles active, DACK may be driven
- eop  in  1  one-cycle end-of-service pulse (terminal count or external EOP)
- hrq  out  1  hold request to CPU
- VALID_DREQ0..VALID_DREQ3  out  1 each  one-hot granted channel to timing control
- dack  out  4  channel acknowledges, polarity per cmd[3]

## Operation
- dreq is registered once (dreq_q). Effective request: r[i] = (dreq_q[i] ^ cmd[2]) & ~mask[i] & ~cmd[0].
- States:
  - IDLE: hrq=0, no grant. If any r, go to HOLD_REQ.
  - HOLD_REQ: hrq=1. If all r drop before hlda, go to IDLE. If hlda=1, resolve priority on current r, latch grant g, go to SERVICE.
  - SERVICE: hrq=1 and VALID_DREQg=1. On eop, go to IDLE and update the pointer if rotating. On hlda=0 without eop, abort to IDLE with no pointer update.
- Priority:
  - Fixed (cmd[1]=0): ch0 is highest.
  - Rotating (cmd[1]=1): prio_ptr names the highest channel, and the search is circular from prio_ptr upward. After eop for channel g, prio_ptr = (g+1) mod 4 (2-bit wrap).
  - A cmd_wr with cmd_din[1]=0 clears prio_ptr to 0.
- dack[i] active when state==SERVICE && g==i && validDACK. The level is inverted when cmd[3]=0.
- Writes during SERVICE do not abort the current service:
  - mask_wr masking channel g: service continues until eop.
  - cmd[0] set: service continues, and no new hrq is raised afterwards.
- Same-cycle events:
  - mask_wr and cmd_wr both apply.
  - eop together with hlda=0: eop wins, and rotation is applied.
  - eop outside SERVICE is ignored.
- Reset values: state IDLE, hrq 0, VALID_DREQ0..3 0, mask 4'hF, cmd 4'h0, prio_ptr 0, dreq_q 0, dack 4'hF (inactive, active-low default).

## Timing
- dreq asserted before edge 0 is sampled at edge 0, and hrq is high after edge 1 (two-cycle request latency).
- hlda high before edge m: grant is latched at edge m, so VALID_DREQg is high after edge m.
- dack is combinational from validDACK and follows it in the same cycle.
- eop high before edge n: hrq, VALID_DREQg and dack deassert after edge n. A new hrq can assert after edge n+1 at the earliest.
- Register writes take effect on the following cycle's effective-request evaluation.

## Structure
- Shared package dma_pkg holds:
  - state enum {IDLE, HOLD_REQ, SERVICE};
  - cmd bit index constants CMD_DIS, CMD_ROT, CMD_DREQ_LO, CMD_DACK_HI;
  - NUM_CH=4.
- Sub-module dma_prio_encoder: combinational, takes r[3:0] and prio_ptr[1:0], returns grant_onehot[3:0] and grant_idx[1:0].
- Top holds registers, the FSM and output polarity logic.

## Test plan
- Reset, then mask_wr 4'h0 and dreq=4'b0100. Required: hrq high two cycles later. hlda=1 gives VALID_DREQ2=1 the next cycle. validDACK=1 gives dack=4'b1011.
- Fixed priority with dreq=4'b1010, then hlda. Required: ch1 granted. After eop with dreq held, re-request grants ch1 again.
- Rotating (cmd_din=4'b0010) with dreq=4'b1111. Required: grant order ch0, ch1, ch2, ch3, ch0 across five eop/hlda cycles.
- mask_din=4'b0001 with dreq=4'b0001. Required: hrq stays 0. Then mask_wr 4'h0 gives hrq=1 two cycles later.
- Drop dreq in HOLD_REQ before hlda. Required: hrq falls, FSM returns to IDLE, no grant.
- Assert RESET in SERVICE. Required: next cycle hrq=0, VALID_DREQ all 0, dack=4'hF, mask=4'hF.
